// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK modulator: scheduler states, default phase width,
// and the Gray dibit to carrier-phase mapping.
package qpsk_pkg;

    localparam int QPSK_PH_W = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        RUN  = 2'd3
    } state_e;

    // Odd octant (2*k+1) per Gray index k; the phase word is this value placed in the top 3 bits.
    localparam logic [2:0] OCT_00 = 3'd1;
    localparam logic [2:0] OCT_01 = 3'd3;
    localparam logic [2:0] OCT_11 = 3'd5;
    localparam logic [2:0] OCT_10 = 3'd7;

    function automatic logic [2:0] dibit_octant(input logic [1:0] dibit);
        logic [2:0] oct;
        oct = OCT_00;
        case (dibit)
            2'b00: oct = OCT_00;
            2'b01: oct = OCT_01;
            2'b11: oct = OCT_11;
            2'b10: oct = OCT_10;
            default: oct = OCT_00;
        endcase
        return oct;
    endfunction

endpackage

// File: rtl/qpsk_nco_ctrl.sv
// Symbol scheduler for the I/Q cosine NCO: accepts Gray dibits, restarts the NCO at the
// symbol phase, hides the NCO fill latency, then flags SYM_LEN valid samples per symbol.
module qpsk_nco_ctrl
    import qpsk_pkg::*;
#(
    parameter int PH_W      = QPSK_PH_W,
    parameter int SYM_LEN   = 64,
    parameter int NCO_LAT   = 5,
    parameter int PHI_Q_OFS = 0
) (
    input  logic            clk_fs,
    input  logic            rst,
    input  logic            enable,
    input  logic [PH_W-1:0] cfg_omega,
    input  logic            sym_valid,
    output logic            sym_ready,
    input  logic [1:0]      sym_data,
    output logic            nco_rst_n,
    output logic [PH_W-1:0] omega_n_I,
    output logic [PH_W-1:0] omega_n_Q,
    output logic [PH_W-1:0] phi_n_I,
    output logic [PH_W-1:0] phi_n_Q,
    output logic            mod_valid,
    output logic            sym_start,
    output logic            underrun
);

    localparam int CNT_W = $clog2(SYM_LEN);
    localparam int LAT_W = $clog2(NCO_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(NCO_LAT - 1);
    localparam logic [PH_W-1:0]  Q_OFS    = PH_W'(PHI_Q_OFS);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [PH_W-1:0] omega_q, omega_d;
    logic [PH_W-1:0] phi_i_q, phi_i_d;
    logic [PH_W-1:0] phi_q_q, phi_q_d;
    logic            underrun_q, underrun_d;

    logic            sym_last;
    logic            xfer;
    logic [PH_W-1:0] phi_map;

    assign sym_last = (state_q == RUN) && (cnt_q == CNT_LAST);
    assign phi_map  = {dibit_octant(sym_data), {(PH_W-3){1'b0}}};

    // Outputs are forced inactive while rst is high so nothing is accepted or released during reset.
    assign sym_ready = !rst && enable && ((state_q == IDLE) || sym_last);
    assign xfer      = sym_valid && sym_ready;
    assign nco_rst_n = !rst && ((state_q == FILL) || (state_q == RUN));
    assign mod_valid = !rst && (state_q == RUN);
    assign sym_start = !rst && (state_q == RUN) && (cnt_q == '0);

    assign omega_n_I = omega_q;
    assign omega_n_Q = omega_q;
    assign phi_n_I   = phi_i_q;
    assign phi_n_Q   = phi_q_q;
    assign underrun  = underrun_q;

    // NOTE: every next-state variable gets its hold value first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        omega_d    = omega_q;
        phi_i_d    = phi_i_q;
        phi_q_d    = phi_q_q;
        underrun_d = underrun_q;

        case (state_q)
            IDLE: begin
                if (xfer) state_d = LOAD;
            end
            LOAD: begin
                state_d = FILL;
                lat_d   = '0;
            end
            FILL: begin
                if (lat_q == LAT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RUN: begin
                if (sym_last) begin
                    if (xfer) begin
                        state_d = LOAD;
                    end else begin
                        if (enable) underrun_d = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            omega_d = cfg_omega;
            phi_i_d = phi_map;
            phi_q_d = phi_map + Q_OFS;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lat_q      <= '0;
            omega_q    <= '0;
            phi_i_q    <= '0;
            phi_q_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            omega_q    <= omega_d;
            phi_i_q    <= phi_i_d;
            phi_q_q    <= phi_q_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_qpsk_nco_ctrl.sv
// Directed bench for qpsk_nco_ctrl: reset, single symbol timing, back-to-back stream,
// Q offset wrap, enable drop and mid-symbol frequency change.
module tb_qpsk_nco_ctrl;

    logic        clk_fs = 1'b0;
    logic        rst;
    logic        enable;
    logic [13:0] cfg_omega;
    logic        sym_valid;
    logic [1:0]  sym_data;

    logic        sym_ready, nco_rst_n, mod_valid, sym_start, underrun;
    logic [13:0] omega_n_I, omega_n_Q, phi_n_I, phi_n_Q;

    logic        sym_ready2, nco_rst_n2, mod_valid2, sym_start2, underrun2;
    logic [13:0] omega_n_I2, omega_n_Q2, phi_n_I2, phi_n_Q2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    qpsk_nco_ctrl dut (
        .clk_fs(clk_fs), .rst(rst), .enable(enable), .cfg_omega(cfg_omega),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data),
        .nco_rst_n(nco_rst_n), .omega_n_I(omega_n_I), .omega_n_Q(omega_n_Q),
        .phi_n_I(phi_n_I), .phi_n_Q(phi_n_Q), .mod_valid(mod_valid),
        .sym_start(sym_start), .underrun(underrun)
    );

    qpsk_nco_ctrl #(.PHI_Q_OFS(4096)) dut_ofs (
        .clk_fs(clk_fs), .rst(rst), .enable(enable), .cfg_omega(cfg_omega),
        .sym_valid(sym_valid), .sym_ready(sym_ready2), .sym_data(sym_data),
        .nco_rst_n(nco_rst_n2), .omega_n_I(omega_n_I2), .omega_n_Q(omega_n_Q2),
        .phi_n_I(phi_n_I2), .phi_n_Q(phi_n_Q2), .mod_valid(mod_valid2),
        .sym_start(sym_start2), .underrun(underrun2)
    );

    always #50 clk_fs = ~clk_fs;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_fs);
        #1;
        cyc++;
    endtask

    // Offer a symbol, wait (bounded) for sym_ready, take the transfer edge; returns in LOAD.
    task automatic accept(input logic [1:0] d, input logic [13:0] w);
        int t;
        sym_data  = d;
        cfg_omega = w;
        sym_valid = 1'b1;
        #1;
        t = 0;
        while (!sym_ready && t < 200) begin
            step();
            t++;
        end
        if (!sym_ready) check("accept_timeout", 0, 1);
        step();
        sym_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_mv, mv_cnt, ss_cnt, ss_k, nrst_low, low, last_cyc, t;
        logic [1:0] stream_d [4];
        int         stream_phi [4];
        stream_d   = '{2'b00, 2'b01, 2'b11, 2'b10};
        stream_phi = '{2048, 6144, 10240, 14336};

        // Power-up reset with a symbol pending: nothing may be accepted.
        rst = 1'b1; enable = 1'b1; sym_valid = 1'b1; sym_data = 2'b01; cfg_omega = 14'd999;
        step(); step();
        check("por_sym_ready", int'(sym_ready), 0);
        check("por_nco_rst_n", int'(nco_rst_n), 0);
        check("por_mod_valid", int'(mod_valid), 0);
        check("por_phi_I", int'(phi_n_I), 0);
        check("por_omega_I", int'(omega_n_I), 0);
        sym_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("idle_sym_ready", int'(sym_ready), 1);

        // Single symbol 00 at omega 1638.
        accept(2'b00, 14'd1638);
        check("load_phi_I", int'(phi_n_I), 2048);
        check("load_phi_Q", int'(phi_n_Q), 2048);
        check("load_omega_I", int'(omega_n_I), 1638);
        check("load_omega_Q", int'(omega_n_Q), 1638);
        check("load_nco_rst_n", int'(nco_rst_n), 0);
        check("load_sym_ready", int'(sym_ready), 0);
        check("ofs_phi_Q_00", int'(phi_n_Q2), 6144);
        first_mv = -1; mv_cnt = 0; ss_cnt = 0; ss_k = -1; nrst_low = 0;
        for (int k = 1; k <= 71; k++) begin
            if (mod_valid) begin
                mv_cnt++;
                if (first_mv < 0) first_mv = k;
            end
            if (sym_start) begin
                ss_cnt++;
                ss_k = k;
            end
            if (k <= 70 && !nco_rst_n) nrst_low++;
            if (k == 70) begin
                check("last_sym_ready", int'(sym_ready), 1);
                check("underrun_pre", int'(underrun), 0);
            end
            if (k < 71) step();
        end
        check("first_mod_valid_k", first_mv, 7);
        check("mod_valid_len", mv_cnt, 64);
        check("sym_start_cnt", ss_cnt, 1);
        check("sym_start_k", ss_k, 7);
        check("nco_rst_low_cycles", nrst_low, 1);
        check("underrun_set", int'(underrun), 1);
        check("idle_omega_hold", int'(omega_n_I), 1638);

        // Reset held 3 cycles mid-RUN with a symbol offered.
        accept(2'b11, 14'd500);
        repeat (20) step();
        check("midrun_mod_valid", int'(mod_valid), 1);
        sym_valid = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_nco_rst_n", int'(nco_rst_n), 0);
            check("rst_mod_valid", int'(mod_valid), 0);
            check("rst_sym_ready", int'(sym_ready), 0);
            check("rst_underrun", int'(underrun), 0);
        end
        sym_valid = 1'b0;
        rst = 1'b0;
        step();
        check("post_rst_nco_rst_n", int'(nco_rst_n), 0);
        check("post_rst_mod_valid", int'(mod_valid), 0);

        // Back-to-back stream 00,01,11,10 with sym_valid held high.
        sym_data = stream_d[0]; sym_valid = 1'b1;
        #1;
        t = 0;
        while (!sym_ready && t < 200) begin step(); t++; end
        step();
        last_cyc = cyc;
        check("stream_phi_0", int'(phi_n_I), stream_phi[0]);
        for (int i = 1; i < 4; i++) begin
            sym_data = stream_d[i];
            low = 0;
            t = 0;
            while (t < 200) begin
                if (!mod_valid) low++;
                if (sym_ready) break;
                step();
                t++;
            end
            if (!sym_ready) check("stream_timeout", 0, 1);
            step();
            check("stream_period", cyc - last_cyc, 70);
            check("stream_gap", low, 6);
            check("stream_phi", int'(phi_n_I), stream_phi[i]);
            check("stream_underrun", int'(underrun), 0);
            last_cyc = cyc;
        end
        check("ofs_phi_Q_wrap", int'(phi_n_Q2), 2048);
        check("ofs_phi_I", int'(phi_n_I2), 14336);
        sym_valid = 1'b0;

        // Enable dropped at RUN cnt=10: symbol completes, no underrun.
        do_reset(2);
        enable = 1'b1;
        accept(2'b11, 14'd1638);
        mv_cnt = 0;
        for (int k = 1; k <= 71; k++) begin
            if (k == 17) enable = 1'b0;
            #1;
            if (mod_valid) mv_cnt++;
            if (k == 70) check("endrop_last_ready", int'(sym_ready), 0);
            if (k < 71) step();
        end
        check("endrop_mv_len", mv_cnt, 64);
        check("endrop_idle_mv", int'(mod_valid), 0);
        check("endrop_idle_ready", int'(sym_ready), 0);
        check("endrop_underrun", int'(underrun), 0);
        check("endrop_nco_rst_n", int'(nco_rst_n), 0);

        // cfg_omega changed at RUN cnt=20: held until the next accept.
        enable = 1'b1;
        accept(2'b01, 14'd1638);
        for (int k = 1; k <= 70; k++) begin
            if (k == 27) cfg_omega = 14'd3276;
            if (k == 60) begin
                sym_data = 2'b10;
                sym_valid = 1'b1;
            end
            #1;
            if (k == 50) begin
                check("omega_hold_run", int'(omega_n_I), 1638);
                check("phi_hold_run", int'(phi_n_I), 6144);
            end
            if (k < 70) step();
        end
        check("omega_last_ready", int'(sym_ready), 1);
        step();
        sym_valid = 1'b0;
        check("omega_new", int'(omega_n_I), 3276);
        check("omega_new_Q", int'(omega_n_Q), 3276);
        check("phi_new", int'(phi_n_I), 14336);
        check("omega_underrun", int'(underrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
